id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
// - ID/EX pipeline register of the 5-stage MIPS pipeline. Sits directly downstream of register_file
//   and the decoder. Captures r_data1/r_data2, immediate, destination and control for the EX stage.
// - Detects load-use hazards: stalls IF/ID and injects a bubble. Handles branch flush and memory hold.
// - Keeps a saturating count of stall cycles for performance debug.
// PARAMETERS
// - DATA_WIDTH   default `DATA_WIDTH (32)  width of operands and immediate
// - ALUOP_W      default 4                 width of the ALU operation code
// - CNT_W        default 16                width of the stall-cycle counter
// PORTS
// - clk           in   1           pipeline clock, rising edge
// - rst           in   1           asynchronous, active-high reset
// - id_valid      in   1           ID holds a real instruction
// - id_rs         in   5           source register 1 index (as sent to register_file)
// - id_rt         in   5           source register 2 index
// - id_rd         in   5           destination register index
// - id_r_data1    in   DATA_WIDTH  register_file r_data1
// - id_r_data2    in   DATA_WIDTH  register_file r_data2
// - id_imm        in   DATA_WIDTH  sign-extended immediate
// - id_reg_write  in   1           control: writes register file
// - id_mem_read   in   1           control: load
// - id_mem_write  in   1           control: store
// - id_alu_src    in   1           control: 1 = immediate operand
// - id_alu_op     in   ALUOP_W     control: ALU operation
// - flush         in   1           branch/jump resolved taken in EX; kill ID instruction
// - mem_hold      in   1           downstream memory stall; freeze ID/EX
// - ex_valid      out  1           EX stage holds a real instruction
// - ex_rs, ex_rt, ex_rd  out 5     registered indices (ex_rs/ex_rt are used by forwarding)
// - ex_a, ex_b, ex_imm   out DATA_WIDTH  registered operands and immediate
// - ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out 1  registered control
// - ex_alu_op     out  ALUOP_W     registered ALU operation
// - stall_ifid    out  1           combinational; 1 = hold PC and IF/ID this cycle
// - stall_cnt     out  CNT_W       saturating count of load-use stall cycles
// BEHAVIOUR
// - Reset (async, rst=1): every registered output = 0, including ex_valid and stall_cnt.
//   After reset, ex_* behave as a bubble.
// - Hazard, combinational:
//   luh = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs | ex_rd==id_rt)
// - stall_ifid = (luh & ~flush) | mem_hold.
// - Per rising edge, priority high to low:
//   1. flush    -> load a bubble: ex_valid=0, all control outputs=0. Data fields are don't-care
//                  and are loaded as 0. stall_cnt is unchanged.
//   2. mem_hold -> hold every ex_* output unchanged.
//   3. luh      -> load a bubble; stall_cnt += 1.
//   4. otherwise -> capture all id_* into ex_*, with ex_valid=id_valid.
//                  When id_valid=0, control outputs are forced to 0.
// - Latency: 1 cycle from ID to EX.
// - A load-use stall lasts exactly 1 cycle. In the next cycle the EX bubble has ex_mem_read=0,
//   so luh drops.
// - A bubble never asserts ex_reg_write, ex_mem_read or ex_mem_write.
// - Destination r0: a load with ex_rd=0 never creates a hazard. This matches register_file,
//   which suppresses writes to r0.
// - flush together with luh: flush wins, no stall, no count. The ID instruction is dead.
// - mem_hold together with luh: hold wins, no count. luh is re-evaluated once the hold releases.
// - stall_cnt saturates at all ones and never wraps.
// - Operands are passed through unmodified. Forwarding is done in EX, not here.
// - register_file write-through covers the WB->ID case. No WB hazard logic is needed here.
// STRUCTURE
// - Shared package/define.sv: DATA_WIDTH, ALUOP_W, and a typedef ctrl_t {reg_write, mem_read,
//   mem_write, alu_src, alu_op}. ctrl_t holds the control bundle as one packed struct.
//   Also in the package: constant CTRL_BUBBLE = '0.
// - Sub-module: hazard_detect, combinational, computes luh. It is reused by the forwarding unit.
//   The register, priority mux and counter stay in id_ex_stage.
// TESTING
// - Reset: assert rst mid-stream with ex_valid=1 -> all outputs read 0 asynchronously, before any
//   clk edge.
// - Pass-through: id_rs=1, rt=2, rd=3, r_data1=0x11, r_data2=0x22, imm=0xFFFF_FFFC, alu_op=2, valid=1
//   -> next cycle ex_* equal these values; stall_ifid=0.
// - Load-use: EX holds lw, rd=5. ID holds add, rs=5
//   -> stall_ifid=1 for 1 cycle; bubble (ex_valid=0); stall_cnt 0->1.
//   The held add then enters EX in the following cycle.
// - r0 load: EX holds lw, rd=0. ID holds rs=0 -> no stall; stall_cnt stays 0.
// - Flush vs hazard: luh condition plus flush=1 -> stall_ifid=0; bubble loaded; stall_cnt unchanged.
// - Hold and saturation: mem_hold=1 for 3 cycles -> ex_* frozen and stall_ifid=1.
//   With CNT_W=2, 5 load-use stalls -> stall_cnt=3, no wrap.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its hazard logic.
package id_ex_stage_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ALUOP_W    = 4;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // All-zero control never writes the register file or touches memory.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection. A load in EX whose destination matches an ID source must stall one cycle.
module hazard_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       luh
);

    // r0 is never written, so a load into it cannot create a dependency.
    assign luh = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs) | (ex_rd == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion, branch flush, memory hold
// and a saturating stall-cycle counter.
module id_ex_stage #(
    parameter int DATA_WIDTH = id_ex_stage_pkg::DATA_WIDTH,
    parameter int ALUOP_W    = id_ex_stage_pkg::ALUOP_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [4:0]            id_rs,
    input  logic [4:0]            id_rt,
    input  logic [4:0]            id_rd,
    input  logic [DATA_WIDTH-1:0] id_r_data1,
    input  logic [DATA_WIDTH-1:0] id_r_data2,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic [ALUOP_W-1:0]    id_alu_op,
    input  logic                  flush,
    input  logic                  mem_hold,
    output logic                  ex_valid,
    output logic [4:0]            ex_rs,
    output logic [4:0]            ex_rt,
    output logic [4:0]            ex_rd,
    output logic [DATA_WIDTH-1:0] ex_a,
    output logic [DATA_WIDTH-1:0] ex_b,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic                  stall_ifid,
    output logic [CNT_W-1:0]      stall_cnt
);

    import id_ex_stage_pkg::*;

    logic                  valid_q, valid_d;
    logic [4:0]            rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    ctrl_t                 ctrl_q, ctrl_d, id_ctrl;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  luh;

    assign id_ctrl = '{reg_write: id_reg_write, mem_read: id_mem_read,
                       mem_write: id_mem_write, alu_src: id_alu_src, alu_op: id_alu_op};

    hazard_detect u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .luh         (luh)
    );

    assign stall_ifid = (luh & ~flush) | mem_hold;

    // NOTE: every _d gets a default first so no path through the priority chain infers a latch.
    always_comb begin
        valid_d = valid_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;

        if (flush || (!mem_hold && luh)) begin
            valid_d = 1'b0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            a_d     = '0;
            b_d     = '0;
            imm_d   = '0;
            ctrl_d  = CTRL_BUBBLE;
            // Only genuine load-use stalls are counted; a flush kills the stalled instruction.
            if (!flush && cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!mem_hold) begin
            valid_d = id_valid;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            a_d     = id_r_data1;
            b_d     = id_r_data2;
            imm_d   = id_imm;
            ctrl_d  = id_valid ? id_ctrl : CTRL_BUBBLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            ctrl_q  <= CTRL_BUBBLE;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_rd        = rd_q;
    assign ex_a         = a_q;
    assign ex_b         = b_q;
    assign ex_imm       = imm_q;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_alu_src   = ctrl_q.alu_src;
    assign ex_alu_op    = ctrl_q.alu_op;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, load-use stall, r0 load, flush, hold, reset, saturation.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid, id_reg_write, id_mem_read, id_mem_write, id_alu_src;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [DW-1:0] id_r_data1, id_r_data2, id_imm;
    logic [AW-1:0] id_alu_op;
    logic          flush, mem_hold;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_a, ex_b, ex_imm;
    logic [AW-1:0] ex_alu_op;
    logic          stall_ifid;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(DW), .ALUOP_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_r_data1(id_r_data1), .id_r_data2(id_r_data2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .flush(flush), .mem_hold(mem_hold),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .stall_ifid(stall_ifid), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] imm, input logic rw, input logic mr,
                            input logic mw, input logic as, input logic [AW-1:0] op);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_r_data1 = a; id_r_data2 = b; id_imm = imm;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_alu_src = as; id_alu_op = op;
    endtask

    // lw rd, 8(rs): reg_write, mem_read, alu_src, alu_op=0
    task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rd);
        drive_id(1'b1, rs, 5'd0, rd, 32'h100, 32'h0, 32'd8, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        flush = 1'b0; mem_hold = 1'b0;
        #1;
        checks++;
        if ({ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_alu_src, ex_alu_op, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_init: ex_valid=%b ex_a=%h stall_cnt=%0d, required all zero",
                     ex_valid, ex_a, stall_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_pass_through();
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        #1;
        checks++;
        if (stall_ifid !== 1'b0) begin
            errors++; $display("FAIL pass_stall: stall_ifid=%b required 0", stall_ifid);
        end
        tick();
        checks++;
        if ({ex_valid, ex_rs, ex_rt, ex_rd} !== {1'b1, 5'd1, 5'd2, 5'd3}) begin
            errors++;
            $display("FAIL pass_idx: valid=%b rs=%0d rt=%0d rd=%0d required 1/1/2/3",
                     ex_valid, ex_rs, ex_rt, ex_rd);
        end
        checks++;
        if ({ex_a, ex_b, ex_imm} !== {32'h11, 32'h22, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL pass_data: a=%h b=%h imm=%h required 11/22/fffffffc", ex_a, ex_b, ex_imm);
        end
        checks++;
        if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op} !== {4'b1000, 4'd2}) begin
            errors++;
            $display("FAIL pass_ctrl: rw=%b mr=%b mw=%b as=%b op=%0d required 1/0/0/0/2",
                     ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op);
        end
        // Invalid ID slot: control must be forced off, data still captured.
        drive_id(1'b0, 5'd4, 5'd5, 5'd6, 32'h33, 32'h44, 32'h5, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
        tick();
        checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op} !== '0 ||
            ex_a !== 32'h33) begin
            errors++;
            $display("FAIL invalid_ctrl: valid=%b rw=%b mr=%b mw=%b as=%b op=%0d a=%h required 0s, a=33",
                     ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op, ex_a);
        end
    endtask

    task automatic test_load_use();
        drive_lw(5'd1, 5'd5);
        tick();
        drive_id(1'b1, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        #1;
        checks++;
        if (stall_ifid !== 1'b1) begin
            errors++; $display("FAIL lu_stall: stall_ifid=%b required 1", stall_ifid);
        end
        tick();
        checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0 || stall_cnt !== 2'd1) begin
            errors++;
            $display("FAIL lu_bubble: valid=%b rw=%b mr=%b mw=%b cnt=%0d required 0/0/0/0 cnt=1",
                     ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall_cnt);
        end
        checks++;
        if (stall_ifid !== 1'b0) begin
            errors++; $display("FAIL lu_release: stall_ifid=%b required 0", stall_ifid);
        end
        tick();
        checks++;
        if ({ex_valid, ex_rs, ex_rd, ex_a} !== {1'b1, 5'd5, 5'd7, 32'hA} || stall_cnt !== 2'd1) begin
            errors++;
            $display("FAIL lu_held_add: valid=%b rs=%0d rd=%0d a=%h cnt=%0d required 1/5/7/a cnt=1",
                     ex_valid, ex_rs, ex_rd, ex_a, stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        // EX holds a valid add and stall_cnt=1; reset must clear them with no clock edge.
        rst = 1'b1;
        #2;
        checks++;
        if ({ex_valid, ex_rs, ex_rd, ex_a, ex_reg_write, ex_alu_op, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%b rd=%0d a=%h rw=%b cnt=%0d required all zero",
                     ex_valid, ex_rd, ex_a, ex_reg_write, stall_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_r0_load();
        drive_lw(5'd1, 5'd0);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd9, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        #1;
        checks++;
        if (stall_ifid !== 1'b0) begin
            errors++; $display("FAIL r0_stall: stall_ifid=%b required 0", stall_ifid);
        end
        tick();
        checks++;
        if ({ex_valid, ex_rd} !== {1'b1, 5'd9} || stall_cnt !== 2'd0) begin
            errors++;
            $display("FAIL r0_capture: valid=%b rd=%0d cnt=%0d required 1/9 cnt=0",
                     ex_valid, ex_rd, stall_cnt);
        end
    endtask

    task automatic test_flush_vs_hazard();
        drive_lw(5'd1, 5'd5);
        tick();
        drive_id(1'b1, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
        flush = 1'b1;
        #1;
        checks++;
        if (stall_ifid !== 1'b0) begin
            errors++; $display("FAIL flush_stall: stall_ifid=%b required 0", stall_ifid);
        end
        tick();
        flush = 1'b0;
        checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op} !== '0 ||
            stall_cnt !== 2'd0) begin
            errors++;
            $display("FAIL flush_bubble: valid=%b rw=%b mr=%b mw=%b op=%0d cnt=%0d required 0s cnt=0",
                     ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op, stall_cnt);
        end
    endtask

    task automatic test_hold();
        drive_id(1'b1, 5'd2, 5'd3, 5'd4, 32'hAA, 32'hBB, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
        tick();
        drive_id(1'b1, 5'd8, 5'd9, 5'd10, 32'hCC, 32'hDD, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
        mem_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall_ifid !== 1'b1) begin
                errors++; $display("FAIL hold_stall[%0d]: stall_ifid=%b required 1", i, stall_ifid);
            end
            tick();
            checks++;
            if ({ex_valid, ex_rd, ex_a, ex_b, ex_reg_write, ex_alu_src, ex_alu_op} !==
                {1'b1, 5'd4, 32'hAA, 32'hBB, 1'b1, 1'b1, 4'd3}) begin
                errors++;
                $display("FAIL hold_frozen[%0d]: valid=%b rd=%0d a=%h b=%h op=%0d required 1/4/aa/bb/3",
                         i, ex_valid, ex_rd, ex_a, ex_b, ex_alu_op);
            end
        end
        mem_hold = 1'b0;
        tick();
        checks++;
        if ({ex_rd, ex_a, ex_mem_write, ex_alu_op} !== {5'd10, 32'hCC, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL hold_release: rd=%0d a=%h mw=%b op=%0d required 10/cc/1/5",
                     ex_rd, ex_a, ex_mem_write, ex_alu_op);
        end
        // Hold over a load-use: no count while held, stall counted once released.
        drive_lw(5'd1, 5'd5);
        tick();
        drive_id(1'b1, 5'd6, 5'd5, 5'd7, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        mem_hold = 1'b1;
        tick();
        checks++;
        if ({ex_valid, ex_mem_read, ex_rd} !== {1'b1, 1'b1, 5'd5} || stall_cnt !== 2'd0) begin
            errors++;
            $display("FAIL hold_luh: valid=%b mr=%b rd=%0d cnt=%0d required 1/1/5 cnt=0",
                     ex_valid, ex_mem_read, ex_rd, stall_cnt);
        end
        mem_hold = 1'b0;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || stall_cnt !== 2'd1) begin
            errors++;
            $display("FAIL hold_luh_release: valid=%b cnt=%0d required 0 cnt=1", ex_valid, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        exp_cnt = 1;
        for (int i = 0; i < 5; i++) begin
            drive_lw(5'd1, 5'd5);
            tick();
            drive_id(1'b1, 5'd5, 5'd0, 5'd7, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
            tick();
            exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
            checks++;
            if (stall_cnt !== exp_cnt[CW-1:0] || ex_valid !== 1'b0) begin
                errors++;
                $display("FAIL sat[%0d]: cnt=%0d valid=%b required cnt=%0d valid=0",
                         i, stall_cnt, ex_valid, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_async_reset();
        test_r0_load();
        test_flush_vs_hazard();
        test_hold();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
